// File: rtl/sel_pkg.sv
// sel_pkg -- channel-select constants shared by the select controller and the
// downstream 4:1 LED mux.
//   SEL_W        : width of the channel select
//   SEL_MAX      : highest channel code
//   SEL_A..SEL_D : channel codes 2'b00..2'b11
//   sel_next()   : next channel in scan order, wrapping SEL_MAX to SEL_A
package sel_pkg;

  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_MAX = 2'b11;
  localparam sel_t SEL_A   = 2'b00;
  localparam sel_t SEL_B   = 2'b01;
  localparam sel_t SEL_C   = 2'b10;
  localparam sel_t SEL_D   = 2'b11;

  function automatic sel_t sel_next(input sel_t s);
    return (s == SEL_MAX) ? SEL_A : sel_t'(s + sel_t'(1));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce -- synchronizes a raw push-button, debounces it and emits a
// single-cycle pulse on each accepted press (0->1 of the debounced level).
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   btn    : raw asynchronous button, active-high
//   press  : registered one-cycle pulse per accepted press
// Parameter:
//   DEB_CYCLES : consecutive cycles the synced level must differ from the
//                debounced level before it is accepted (>= 2)
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;

      // cnt holds the number of earlier consecutive cycles that differed;
      // the DEB_CYCLES-th differing cycle is the one seen with cnt at CNT_TC.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      stable_q <= stable;
      press    <= stable & ~stable_q;
    end
  end

endmodule

// File: rtl/sel_scan_ctrl.sv
// sel_scan_ctrl -- 2-bit channel select for a 4:1 LED mux, advanced by a
// debounced push-button and, optionally, by a timed auto-scan.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   btn     : raw asynchronous push-button, active-high
//   auto_en : enables the timed auto-scan (ignored without SEL_AUTO_SCAN_EN)
//   sel     : registered channel select
//   sel_chg : one-cycle pulse in the first cycle sel shows a new value
// Parameters:
//   DEB_CYCLES  : button debounce interval in clocks (>= 2)
//   SCAN_CYCLES : clocks between auto-scan steps (>= 2)
// Build option:
//   SEL_AUTO_SCAN_EN defined   -> auto-scan timer built, auto_en honoured
//   SEL_AUTO_SCAN_EN undefined -> no timer; only presses change sel
module sel_scan_ctrl
  import sel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned SCAN_CYCLES = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic             auto_en,
  output logic [SEL_W-1:0] sel,
  output logic             sel_chg
);

  logic press;
  logic press_q;
  logic tc;
  logic step;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .press(press)
  );

`ifdef SEL_AUTO_SCAN_EN
  localparam int unsigned TW = $clog2(SCAN_CYCLES);
  localparam logic [TW-1:0] SCAN_TC = TW'(SCAN_CYCLES - 1);

  logic [TW-1:0] scan_cnt;

  always_comb begin
    tc = auto_en && (scan_cnt == SCAN_TC);
  end

  // A press restarts the interval; a press landing on terminal count merges
  // with the auto step into one increment because both feed the same step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (!auto_en || step) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + TW'(1);
    end
  end
`else
  localparam int unsigned unused_scan_cycles = SCAN_CYCLES;

  logic unused_auto_en;
  assign unused_auto_en = auto_en;

  always_comb begin
    tc = 1'b0;
  end
`endif

  always_comb begin
    step = press_q | tc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= 1'b0;
      sel     <= SEL_A;
      sel_chg <= 1'b0;
    end else begin
      press_q <= press;
      sel_chg <= step;
      if (step) begin
        sel <= sel_next(sel);
      end
    end
  end

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// tb_sel_scan_ctrl -- self-checking bench for sel_scan_ctrl with
// DEB_CYCLES=4 and SCAN_CYCLES=8: directed scenarios plus random button and
// auto_en activity, every cycle compared against a behavioural model.
module tb_sel_scan_ctrl;

  localparam int DEB  = 4;
  localparam int SCAN = 8;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       auto_en;
  logic [1:0] sel;
  logic       sel_chg;

  int errors = 0;
  int checks = 0;

  sel_scan_ctrl #(
    .DEB_CYCLES (DEB),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .auto_en(auto_en),
    .sel    (sel),
    .sel_chg(sel_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // btn samples per edge; the debouncer sees each sample two edges later.
  bit bq[$];
  // synced samples seen since the debounced level last changed
  bit synq[$];
  // edge numbers at which a press increments sel
  int pend[$];
  bit m_stable;
  int m_tmr;
  int m_sel;
  bit m_chg;
  int edge_no;

  task automatic model_reset();
    bq = {1'b0, 1'b0};
    synq.delete();
    pend.delete();
    m_stable = 1'b0;
    m_tmr    = 0;
    m_sel    = 0;
    m_chg    = 1'b0;
    edge_no  = 0;
  endtask

  task automatic model_edge(input bit b, input bit a);
    bit syn;
    bit all_diff;
    bit pi;
    bit tcm;
    bit stp;
    bq.push_back(b);
    syn = bq[bq.size() - 3];
    while (bq.size() > 2) void'(bq.pop_front());
    synq.push_back(syn);
    while (synq.size() > DEB) void'(synq.pop_front());
    // Accept the synced level once the last DEB samples all disagree.
    all_diff = (synq.size() == DEB);
    foreach (synq[i]) if (synq[i] == m_stable) all_diff = 1'b0;
    if (all_diff) begin
      m_stable = ~m_stable;
      synq.delete();
      // An accepted rise reaches sel three edges later (DEB+4 from the raw sample).
      if (m_stable) pend.push_back(edge_no + 3);
    end
    pi = 1'b0;
    if (pend.size() > 0 && pend[0] == edge_no) begin
      pi = 1'b1;
      void'(pend.pop_front());
    end
`ifdef SEL_AUTO_SCAN_EN
    tcm = a && (m_tmr == SCAN - 1);
`else
    tcm = 1'b0;
`endif
    stp = pi | tcm;
    m_tmr = (!a || stp) ? 0 : m_tmr + 1;
    if (stp) m_sel = (m_sel + 1) % 4;
    m_chg = stp;
    edge_no++;
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; ends at the next falling edge.
  task automatic cyc(input bit b, input bit a);
    btn     = b;
    auto_en = a;
    @(posedge clk);
    model_edge(b, a);
    #1;
    check_eq("sel", int'(sel), m_sel);
    check_eq("sel_chg", int'(sel_chg), int'(m_chg));
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n   = 1'b0;
    btn     = 1'b0;
    #1;
    model_reset();
    check_eq("rst_sel", int'(sel), 0);
    check_eq("rst_chg", int'(sel_chg), 0);
    repeat (n) @(negedge clk);
    check_eq("rst_hold_sel", int'(sel), 0);
    rst_n = 1'b1;
  endtask

  int first_chg;
  int n_chg;

  initial begin
    rst_n   = 1'b0;
    btn     = 1'b0;
    auto_en = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Long press: one step, DEB+4 edges after the first high sample.
    first_chg = -1;
    n_chg     = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0);
      if (sel_chg) begin
        n_chg++;
        if (first_chg < 0) first_chg = i;
      end
    end
    check_eq("first_step_edge", first_chg, DEB + 4);
    check_eq("long_press_pulses", n_chg, 1);
    check_eq("long_press_sel", int'(sel), 1);

    // Short glitch is rejected.
    do_reset(2);
    n_chg = 0;
    for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0); n_chg += int'(sel_chg); end
    for (int i = 0; i < 15; i++) begin cyc(1'b0, 1'b0); n_chg += int'(sel_chg); end
    check_eq("glitch_pulses", n_chg, 0);
    check_eq("glitch_sel", int'(sel), 0);

    // Four clean presses wrap sel back to 0.
    n_chg = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 10; i++) begin cyc(1'b1, 1'b0); n_chg += int'(sel_chg); end
      for (int i = 0; i < 10; i++) begin cyc(1'b0, 1'b0); n_chg += int'(sel_chg); end
    end
    check_eq("four_press_pulses", n_chg, 4);
    check_eq("four_press_sel", int'(sel), 0);

    // Auto-scan for 32 cycles, then disabled.
    do_reset(2);
    n_chg = 0;
    for (int i = 0; i < 32; i++) begin cyc(1'b0, 1'b1); n_chg += int'(sel_chg); end
`ifdef SEL_AUTO_SCAN_EN
    check_eq("auto_pulses", n_chg, 4);
`else
    check_eq("auto_pulses", n_chg, 0);
`endif
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
    n_chg = 0;
    for (int i = 0; i < 20; i++) begin cyc(1'b0, 1'b0); n_chg += int'(sel_chg); end
    check_eq("auto_off_pulses", n_chg, 0);
`ifdef SEL_AUTO_SCAN_EN
    check_eq("auto_off_timer", int'(dut.scan_cnt), 0);
`endif

    // Press increment landing on terminal count (edge 15), then auto stepping.
    do_reset(2);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);

    // Auto_en held with the timer absent or present, checked by the model.
    do_reset(2);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1);

    // Reset mid-debounce (counter at 2) and mid-scan.
    do_reset(2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    do_reset(2);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
    check_eq("post_rst_sel", int'(sel), 0);
    for (int i = 0; i < 13; i++) cyc(1'b0, 1'b1);
    do_reset(2);
    n_chg = 0;
    for (int i = 0; i < 20; i++) begin cyc(1'b0, 1'b0); n_chg += int'(sel_chg); end
    check_eq("post_rst_pulses", n_chg, 0);

    // Random button levels, auto_en toggling and occasional resets.
    for (int seg = 0; seg < 200; seg++) begin
      bit b;
      bit a;
      int len;
      if ($urandom_range(0, 24) == 0) do_reset(int'($urandom_range(1, 3)));
      b   = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) != 0) ? auto_en : 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) cyc(b, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sel_scan_ctrl.md
SEL_SCAN_CTRL -- requirements
Module: sel_scan_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1_000_000, is the number of consecutive clocks a synced button level must hold before it is accepted (minimum 2).
REQ-002 Parameter SCAN_CYCLES, default 100_000_000, is the number of clocks between auto-scan steps (minimum 2).
REQ-003 Port clk, input, 1 bit: the single system clock; every flop is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port btn, input, 1 bit: raw, asynchronous push-button, active-high.
REQ-006 Port auto_en, input, 1 bit: when high, enables timed auto-scan of sel.
REQ-007 Port sel, output, 2 bits: registered channel select that drives the downstream 4:1 LED mux.
REQ-008 Port sel_chg, output, 1 bit: registered single-cycle pulse, high in the first cycle sel shows a new value.

Function
REQ-009 btn SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-010 The debouncer SHALL hold a stable level and a counter that clears whenever the synced level equals the stable level.
REQ-011 When the synced level differs from the stable level for DEB_CYCLES consecutive cycles, the stable level SHALL take the synced level and the counter SHALL clear.
REQ-012 A glitch shorter than DEB_CYCLES cycles SHALL NOT change the stable level.
REQ-013 A registered press pulse SHALL assert for exactly one cycle on each 0->1 transition of the stable level; 1->0 transitions SHALL produce no event.
REQ-014 Each press SHALL increment sel by 1 modulo 4, so 3 wraps to 0.
REQ-015 The first sel update SHALL occur DEB_CYCLES+4 rising edges after the first edge that samples btn high, provided btn stays high throughout.
REQ-016 Auto-scan timer, counting only while auto_en=1: it SHALL count 0..SCAN_CYCLES-1 and, at terminal count, increment sel modulo 4 and return to 0.
REQ-017 When auto_en=0, the timer SHALL clear to 0 and hold there.
REQ-018 A press while auto_en=1 SHALL increment sel and restart the timer at 0.
REQ-019 A press coinciding with timer terminal count SHALL cause exactly one increment, and the timer SHALL restart at 0.
REQ-020 sel_chg SHALL assert in the same edge that updates sel and SHALL be 0 in every other cycle.

Reset
REQ-021 While rst_n=0, the following SHALL all be held at 0: sel=2'b00, sel_chg=0, synchronizer flops, stable level, press pulse, debounce counter and scan timer.
REQ-022 Reset asserted mid-debounce or mid-scan SHALL discard all progress; after release, operation SHALL restart from the REQ-021 state with no spurious sel_chg.

Configuration
REQ-023 Macro SEL_AUTO_SCAN_EN defined: the auto-scan timer and auto_en behaviour SHALL be built as in REQ-016..REQ-019.
REQ-024 Macro SEL_AUTO_SCAN_EN undefined: no timer logic SHALL be built, the auto_en port SHALL remain but be ignored, SCAN_CYCLES SHALL be unused, and only presses SHALL change sel.

Structure
REQ-025 Shared package sel_pkg SHALL hold SEL_W=2, SEL_MAX=2'b11 and the channel constants SEL_A..SEL_D=2'b00..2'b11, which the downstream mux shares.
REQ-026 Counter widths SHALL be $clog2 of the respective parameter.
REQ-027 The synchronizer, debouncer and press-pulse logic SHALL live in a sub-module btn_debounce (ports clk, rst_n, btn, press), with DEB_CYCLES passed down.

Verification (DEB_CYCLES=4, SCAN_CYCLES=8)
REQ-028 Reset with btn=0, then hold btn=1 for 20 cycles -> sel 0->1 exactly 8 edges after the first high sample; one sel_chg pulse; no further change.
REQ-029 btn high for 3 cycles, then low -> sel remains 0 and sel_chg never asserts.
REQ-030 Four clean presses, each 10 cycles high and 10 cycles low -> sel goes 1,2,3,0 with four sel_chg pulses.
REQ-031 With macro defined and auto_en=1 -> sel steps every 8 cycles (0,1,2,3,0); with auto_en=0 -> sel holds and the timer reads 0.
REQ-032 Press aligned to timer terminal count -> single increment, and the next auto step occurs 8 cycles later.
REQ-033 rst_n pulsed low mid-debounce (counter=2) and mid-scan -> all outputs 0 immediately; after release with btn=0, sel stays 0.
REQ-034 With macro undefined and auto_en=1 held for 50 cycles -> sel unchanged.
